// File: rtl/loc_fifo.sv
// Parametrised circular FIFO for location words with occupancy status,
// synchronous flush and sticky overflow/underflow flags.
module loc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enqueue,
  input  logic             dequeue,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_acc_enq;
  logic             w_acc_deq;

  // Status decodes only depend on registered count.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FullCount);
  // A full FIFO still accepts a write when a read frees the slot in the same edge.
  assign w_acc_enq = enqueue & (~w_full | dequeue);
  assign w_acc_deq = dequeue & ~w_empty;

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!clear && w_acc_enq) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_acc_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_acc_deq) begin
        // Nonblocking read of the old word gives read-before-write on a shared slot.
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      unique case ({w_acc_enq, w_acc_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (enqueue && !w_acc_enq) begin
        r_overflow <= 1'b1;
      end
      if (dequeue && !w_acc_deq) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign dataOut   = r_data_out;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
